// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing generator
// Optional feature macro: VGA_FRAME_COUNT_EN (builds the 8-bit frame counter;
// otherwise frame_count is tied to zero).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last positions of a line / frame (totals are at most 1024, so these fit in 10 bits).
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VISEND = 10'(V_ACTIVE - 1);

  // Window bounds kept 11 bits wide so an end bound equal to 1024 stays exact.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  // Next raster position plus sync/active flags decoded from that next position,
  // so the registered flags always line up with the registered coordinates.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    active_d = ({1'b0, x_d} < H_ACT_END) && ({1'b0, y_d} < V_ACT_END);
    hsync_d  = (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Position and flag registers; reset parks at the last pixel of the frame so
  // the first enabled edge lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= H_LAST;
      y_q      <= V_LAST;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign x_px        = x_q;
  assign y_px        = y_q;
  assign activevideo = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

  // Strobes are gated by rst_n because the reset position sits on the last pixel.
  assign line_end  = rst_n & pix_en & (x_q == H_LAST);
  assign frame_end = rst_n & pix_en & (x_q == H_LAST) & (y_q == V_VISEND);

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Count completed visible frames, wrapping naturally at 8 bits.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_end) frame_count_d = frame_count_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_count_q <= 8'd0;
    else        frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Reduced raster used for the cycle-level instances so full frames fit in the run.
  localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 6, S_VFP = 1, S_VS = 2, S_VBP = 2;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_TOT = S_HT * S_VT;

  logic clk, rst_n, pix_en;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_av, a_hs, a_vs, a_le, a_fe;
  logic b_av, b_hs, b_vs, b_le, b_fe;
  logic c_av, c_hs, c_vs, c_le, c_fe;
  logic [7:0] a_fc, b_fc, c_fc;

  int checks = 0;
  int errors = 0;
  int k = 0;  // enabled edges since the last reset release

  int cnt_le, cnt_fe, cnt_hs, cnt_vs, cnt_av;

  vga_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                   .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                   .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_px(a_x), .y_px(a_y),
    .activevideo(a_av), .hsync(a_hs), .vsync(a_vs), .line_end(a_le),
    .frame_end(a_fe), .frame_count(a_fc));

  vga_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                   .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                   .SYNC_POL(1'b1)) dut_pos (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_px(b_x), .y_px(b_y),
    .activevideo(b_av), .hsync(b_hs), .vsync(b_vs), .line_end(b_le),
    .frame_end(b_fe), .frame_count(b_fc));

  vga_timing_gen dut_std (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_px(c_x), .y_px(c_y),
    .activevideo(c_av), .hsync(c_hs), .vsync(c_vs), .line_end(c_le),
    .frame_end(c_fe), .frame_count(c_fc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  // Reference: after k enabled edges the raster index is (TOT-1+k) mod TOT,
  // and every output is a plain function of that index.
  task automatic cmp_inst(input string nm, input int cfg,
                          input logic [9:0] x, input logic [9:0] y,
                          input logic av, input logic hs, input logic vs,
                          input logic le, input logic fe, input logic [7:0] fc);
    int ha, hfp, hsy, ht, va, vfp, vsy, vt, tot, idx, ex, ey, efc;
    logic pol, en, eav, ehs, evs;
    if (cfg == 2) begin
      ha = 640; hfp = 16; hsy = 96; ht = 800;
      va = 480; vfp = 10; vsy = 2;  vt = 525;
    end else begin
      ha = S_HA; hfp = S_HFP; hsy = S_HS; ht = S_HT;
      va = S_VA; vfp = S_VFP; vsy = S_VS; vt = S_VT;
    end
    pol = (cfg == 1);
    tot = ht * vt;
    idx = (tot - 1 + k) % tot;
    ex  = idx % ht;
    ey  = idx / ht;
    en  = pix_en && rst_n;
    eav = (ex < ha) && (ey < va);
    ehs = (ex >= ha + hfp && ex < ha + hfp + hsy) ? pol : ~pol;
    evs = (ey >= va + vfp && ey < va + vfp + vsy) ? pol : ~pol;
`ifdef VGA_FRAME_COUNT_EN
    efc = (k > va * ht) ? (((k - 1 - va * ht) / tot + 1) % 256) : 0;
`else
    efc = 0;
`endif
    chk({nm, ".x_px"}, 32'(x), 32'(ex));
    chk({nm, ".y_px"}, 32'(y), 32'(ey));
    chk({nm, ".activevideo"}, 32'(av), 32'(eav));
    chk({nm, ".hsync"}, 32'(hs), 32'(ehs));
    chk({nm, ".vsync"}, 32'(vs), 32'(evs));
    chk({nm, ".line_end"}, 32'(le), 32'(en && ex == ht - 1));
    chk({nm, ".frame_end"}, 32'(fe), 32'(en && ex == ht - 1 && ey == va - 1));
    chk({nm, ".frame_count"}, 32'(fc), 32'(efc));
  endtask

  task automatic check_all();
    cmp_inst("neg", 0, a_x, a_y, a_av, a_hs, a_vs, a_le, a_fe, a_fc);
    cmp_inst("pos", 1, b_x, b_y, b_av, b_hs, b_vs, b_le, b_fe, b_fc);
    cmp_inst("std", 2, c_x, c_y, c_av, c_hs, c_vs, c_le, c_fe, c_fc);
  endtask

  // Called at a falling edge: apply enable, check, take the rising edge.
  task automatic step(input logic en);
    pix_en = en;
    #1;
    check_all();
    if (a_le) cnt_le++;
    if (a_fe) cnt_fe++;
    if (a_hs == 1'b0) cnt_hs++;
    if (a_vs == 1'b0) cnt_vs++;
    if (a_av) cnt_av++;
    @(posedge clk);
    if (en) k++;
    @(negedge clk);
  endtask

  task automatic clear_counts();
    cnt_le = 0; cnt_fe = 0; cnt_hs = 0; cnt_vs = 0; cnt_av = 0;
  endtask

  initial begin
    bit reached;
    rst_n  = 1'b0;
    pix_en = 1'b1;
    clear_counts();
    @(negedge clk);
    #1;
    check_all();  // reset state with pix_en high: strobes must still be 0

    rst_n = 1'b1;
    #1;
    // One full enabled frame of the reduced raster, with aggregate counts.
    clear_counts();
    repeat (S_TOT) step(1'b1);
    chk("frame.line_end_count", 32'(cnt_le), 32'(S_VT));
    chk("frame.frame_end_count", 32'(cnt_fe), 32'd1);
    chk("frame.hsync_cycles", 32'(cnt_hs), 32'(S_HS * S_VT));
    chk("frame.vsync_cycles", 32'(cnt_vs), 32'(S_VS * S_HT));
    chk("frame.active_cycles", 32'(cnt_av), 32'(S_HA * S_VA));

    // Random enable pattern; model tracks enabled edges only.
    repeat (4 * S_TOT) step(1'($urandom_range(0, 1)));

    // Walk to a mid-frame position, then pulse reset for half a cycle.
    reached = 1'b0;
    for (int i = 0; i < 2 * S_TOT && !reached; i++) begin
      if (a_x == 10'd5 && a_y == 10'd3) reached = 1'b1;
      else step(1'b1);
    end
    chk("walk.reached_5_3", 32'(reached), 32'd1);
    pix_en = 1'b1;
    #1;
    rst_n = 1'b0;
    k = 0;
    #1;
    check_all();  // must already be in reset state, no clock edge seen
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    k++;
    @(negedge clk);

    clear_counts();
    repeat (2 * S_TOT) step(1'b1);
    chk("restart.frame_end_count", 32'(cnt_fe), 32'd2);
    chk("restart.line_end_count", 32'(cnt_le), 32'(2 * S_VT));

    // Cover the default-geometry hsync window (starts at x=656).
    repeat (760) step(1'($urandom_range(0, 7) != 0));

`ifdef VGA_FRAME_COUNT_EN
    // Enough frames to wrap the 8-bit counter.
    repeat (257 * S_TOT) step(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
